// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: default widths, FSM state encoding,
// access-width encodings and the fetch/load-store grant decision.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF       = 32;
   localparam int DATA_W_DEF       = 32;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int DBG_CNT_W        = 8;

   // Fetch is always a full-word read.
   localparam logic [2:0] BYTE_NUM_4 = 3'd4;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_LS = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_LS   = 2'd2
   } grant_e;

   // Load/store wins a tie because it commits at the ROB head, unless fetch has
   // already lost enough consecutive ties.
   function automatic grant_e pick_grant(input logic if_req,
                                         input logic ls_req,
                                         input logic if_starved);
      if (ls_req && !(if_req && if_starved)) return GNT_LS;
      if (if_req)                            return GNT_IF;
      return GNT_NONE;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (reads) and the load/store unit,
// one transaction at a time, with load/store priority and a fetch starvation guard.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [ADDR_W-1:0]    if_addr,
   output logic                 if_done,
   output logic [DATA_W-1:0]    if_rdata,
   input  logic                 ls_req,
   input  logic                 ls_we,
   input  logic [ADDR_W-1:0]    ls_addr,
   input  logic [2:0]           ls_byte_num,
   input  logic [DATA_W-1:0]    ls_wdata,
   output logic                 ls_done,
   output logic [DATA_W-1:0]    ls_rdata,
   output logic                 mem_rd_en,
   output logic                 mem_wr_en,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [2:0]           mem_byte_num,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 mem_rd_done,
   input  logic                 mem_wr_done,
   output logic [1:0]           dbg_state,
   output logic [DBG_CNT_W-1:0] dbg_starve_cnt
);

   // Handshakes: a requester raises x_req (level) with stable payload and holds it
   // until x_done pulses for one cycle; it must drop x_req in that same done cycle or
   // the arbiter treats it as a new request. Toward memory, mem_rd_en/mem_wr_en stay
   // high with stable payload until the matching mem_rd_done/mem_wr_done is seen.

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   arb_state_e          state_q;
   logic [CNT_W-1:0]    starve_cnt_q;
   logic                mem_rd_en_q;
   logic                mem_wr_en_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [2:0]          mem_byte_num_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                if_done_q;
   logic                ls_done_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   ls_rdata_q;

   grant_e              grant_d;
   logic                if_starved_d;
   logic                ls_complete_d;

   assign if_starved_d  = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
   assign grant_d       = pick_grant(if_req, ls_req, if_starved_d);
   assign ls_complete_d = mem_wr_en_q ? mem_wr_done : mem_rd_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ARB_IDLE;
         starve_cnt_q   <= '0;
         mem_rd_en_q    <= 1'b0;
         mem_wr_en_q    <= 1'b0;
         mem_addr_q     <= '0;
         mem_byte_num_q <= '0;
         mem_wdata_q    <= '0;
         if_done_q      <= 1'b0;
         ls_done_q      <= 1'b0;
         if_rdata_q     <= '0;
         ls_rdata_q     <= '0;
      end else begin
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
         unique case (state_q)
            ARB_IDLE: begin
               if (!if_req) starve_cnt_q <= '0;
               unique case (grant_d)
                  GNT_IF: begin
                     state_q        <= ARB_BUSY_IF;
                     starve_cnt_q   <= '0;
                     mem_rd_en_q    <= 1'b1;
                     mem_addr_q     <= if_addr;
                     mem_byte_num_q <= BYTE_NUM_4;
                     mem_wdata_q    <= '0;
                  end
                  GNT_LS: begin
                     state_q        <= ARB_BUSY_LS;
                     if (if_req && !if_starved_d) starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                     mem_rd_en_q    <= !ls_we;
                     mem_wr_en_q    <= ls_we;
                     mem_addr_q     <= ls_addr;
                     mem_byte_num_q <= ls_byte_num;
                     mem_wdata_q    <= ls_wdata;
                  end
                  default: ;
               endcase
            end
            ARB_BUSY_IF: begin
               if (mem_rd_done) begin
                  state_q     <= ARB_IDLE;
                  mem_rd_en_q <= 1'b0;
                  if_rdata_q  <= mem_rdata;
                  if_done_q   <= 1'b1;
               end
            end
            ARB_BUSY_LS: begin
               if (ls_complete_d) begin
                  state_q     <= ARB_IDLE;
                  mem_rd_en_q <= 1'b0;
                  mem_wr_en_q <= 1'b0;
                  if (mem_rd_en_q) ls_rdata_q <= mem_rdata;
                  ls_done_q   <= 1'b1;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign if_done        = if_done_q;
   assign if_rdata       = if_rdata_q;
   assign ls_done        = ls_done_q;
   assign ls_rdata       = ls_rdata_q;
   assign mem_rd_en      = mem_rd_en_q;
   assign mem_wr_en      = mem_wr_en_q;
   assign mem_addr       = mem_addr_q;
   assign mem_byte_num   = mem_byte_num_q;
   assign mem_wdata      = mem_wdata_q;
   assign dbg_state      = state_q;
   assign dbg_starve_cnt = DBG_CNT_W'(starve_cnt_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a small arbitration model and an expected-read-data queue.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 if_req;
   logic [ADDR_W-1:0]    if_addr;
   logic                 if_done;
   logic [DATA_W-1:0]    if_rdata;
   logic                 ls_req;
   logic                 ls_we;
   logic [ADDR_W-1:0]    ls_addr;
   logic [2:0]           ls_byte_num;
   logic [DATA_W-1:0]    ls_wdata;
   logic                 ls_done;
   logic [DATA_W-1:0]    ls_rdata;
   logic                 mem_rd_en;
   logic                 mem_wr_en;
   logic [ADDR_W-1:0]    mem_addr;
   logic [2:0]           mem_byte_num;
   logic [DATA_W-1:0]    mem_wdata;
   logic [DATA_W-1:0]    mem_rdata;
   logic                 mem_rd_done;
   logic                 mem_wr_done;
   logic [1:0]           dbg_state;
   logic [DBG_CNT_W-1:0] dbg_starve_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference state: starvation count and last delivered read data per requester.
   int                m_starve;
   logic [DATA_W-1:0] m_if_rdata;
   logic [DATA_W-1:0] m_ls_rdata;
   logic [DATA_W-1:0] exp_q[$];

   typedef struct packed {
      int                wait_cycles;
      logic              done_at_grant;
      logic              rd_en;
      logic              wr_en;
      logic [ADDR_W-1:0] addr;
      logic [2:0]        byte_num;
      logic [DATA_W-1:0] wdata;
      logic [7:0]        starve;
      logic              spur_ok;
      logic              held;
      logic              if_done;
      logic              ls_done;
      logic              en_after;
      logic [DATA_W-1:0] if_rdata;
      logic [DATA_W-1:0] ls_rdata;
   } obs_t;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_byte_num(ls_byte_num),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_byte_num(mem_byte_num), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done),
      .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic clear_inputs();
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_byte_num = 3'd0; ls_wdata = '0;
      mem_rdata = '0; mem_rd_done = 1'b0; mem_wr_done = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_starve = 0; m_if_rdata = '0; m_ls_rdata = '0;
      exp_q.delete();
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_grant_if(input bit ifp, input bit lsp);
      return ifp && (!lsp || m_starve == STARVE_LIMIT);
   endfunction

   function automatic void model_update(input bit gif, input bit ifp);
      if (gif || !ifp) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
   endfunction

   // ---------------- memory-side driver ----------------
   // Called on a negedge just after requests are set; returns on the negedge where
   // the requester's done pulse should be visible.
   task automatic serve(input int lat, input bit spurious, input bit drop_ls,
                        input logic [DATA_W-1:0] rdata, output obs_t o);
      o = '0;
      do begin
         @(negedge clk);
         o.wait_cycles++;
         if (o.wait_cycles == 1) o.done_at_grant = if_done | ls_done;
      end while (!(mem_rd_en || mem_wr_en) && o.wait_cycles < 8);
      o.rd_en = mem_rd_en; o.wr_en = mem_wr_en; o.addr = mem_addr;
      o.byte_num = mem_byte_num; o.wdata = mem_wdata; o.starve = dbg_starve_cnt;
      if (!(mem_rd_en || mem_wr_en)) return;
      if (drop_ls) ls_req = 1'b0;
      o.spur_ok = 1'b1;
      o.held    = 1'b1;
      if (spurious) begin
         mem_rdata = $urandom;
         if (mem_rd_en) mem_wr_done = 1'b1; else mem_rd_done = 1'b1;
         @(negedge clk);
         mem_rd_done = 1'b0; mem_wr_done = 1'b0;
         o.spur_ok = (mem_rd_en === o.rd_en) && (mem_wr_en === o.wr_en) && !if_done && !ls_done;
      end
      repeat (lat) begin
         @(negedge clk);
         if (mem_rd_en !== o.rd_en || mem_wr_en !== o.wr_en || mem_addr !== o.addr ||
             if_done || ls_done) o.held = 1'b0;
      end
      mem_rdata = rdata;
      if (o.rd_en) mem_rd_done = 1'b1; else mem_wr_done = 1'b1;
      @(negedge clk);
      mem_rd_done = 1'b0; mem_wr_done = 1'b0;
      mem_rdata = $urandom;
      o.if_done = if_done; o.ls_done = ls_done;
      o.en_after = mem_rd_en | mem_wr_en;
      o.if_rdata = if_rdata; o.ls_rdata = ls_rdata;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      if_req = 1'b1; ls_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({mem_rd_en, mem_wr_en, if_done, ls_done} !== 4'b0) begin failures++;
         $display("FAIL reset_ctrl got=%b exp=0000", {mem_rd_en, mem_wr_en, if_done, ls_done}); end
      checks++; if ({mem_addr, mem_byte_num, mem_wdata} !== '0) begin failures++;
         $display("FAIL reset_payload got=%0h/%0h/%0h exp=0", mem_addr, mem_byte_num, mem_wdata); end
      checks++; if ({if_rdata, ls_rdata} !== '0) begin failures++;
         $display("FAIL reset_rdata got=%0h/%0h exp=0", if_rdata, ls_rdata); end
      checks++; if (dbg_state !== ARB_IDLE || dbg_starve_cnt !== 8'd0) begin failures++;
         $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_starve_cnt); end
      do_reset();
   endtask

   task automatic test_if_read();
      obs_t o;
      if_req = 1'b1; if_addr = 32'h100;
      serve(2, 1'b0, 1'b0, 32'hCAFE_0001, o);
      if_req = 1'b0;
      checks++; if (o.wait_cycles !== 1) begin failures++;
         $display("FAIL if_grant_latency got=%0d exp=1", o.wait_cycles); end
      checks++; if ({o.rd_en, o.wr_en} !== 2'b10) begin failures++;
         $display("FAIL if_enables got=%b exp=10", {o.rd_en, o.wr_en}); end
      checks++; if (o.addr !== 32'h100 || o.byte_num !== 3'd4) begin failures++;
         $display("FAIL if_payload got=%0h/%0d exp=100/4", o.addr, o.byte_num); end
      checks++; if (!o.held) begin failures++;
         $display("FAIL if_hold got=%b exp=1", o.held); end
      checks++; if ({o.if_done, o.ls_done, o.en_after} !== 3'b100) begin failures++;
         $display("FAIL if_done got=%b exp=100", {o.if_done, o.ls_done, o.en_after}); end
      checks++; if (o.if_rdata !== 32'hCAFE_0001) begin failures++;
         $display("FAIL if_rdata got=%0h exp=cafe0001", o.if_rdata); end
      m_if_rdata = 32'hCAFE_0001;
      @(negedge clk);
      checks++; if ({if_done, mem_rd_en, mem_wr_en} !== 3'b000 || if_rdata !== m_if_rdata) begin failures++;
         $display("FAIL if_after got=%b/%0h exp=000/%0h", {if_done, mem_rd_en, mem_wr_en}, if_rdata, m_if_rdata); end
   endtask

   task automatic test_ls_store();
      obs_t o;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_byte_num = 3'd1; ls_wdata = 32'hAB;
      serve(1, 1'b1, 1'b0, 32'h5555_AAAA, o);
      ls_req = 1'b0;
      checks++; if ({o.rd_en, o.wr_en} !== 2'b01) begin failures++;
         $display("FAIL st_enables got=%b exp=01", {o.rd_en, o.wr_en}); end
      checks++; if (o.addr !== 32'h20 || o.byte_num !== 3'd1 || o.wdata !== 32'hAB) begin failures++;
         $display("FAIL st_payload got=%0h/%0d/%0h exp=20/1/ab", o.addr, o.byte_num, o.wdata); end
      checks++; if (!o.spur_ok || !o.held) begin failures++;
         $display("FAIL st_spurious_rd_done got=%b%b exp=11", o.spur_ok, o.held); end
      checks++; if ({o.if_done, o.ls_done, o.en_after} !== 3'b010) begin failures++;
         $display("FAIL st_done got=%b exp=010", {o.if_done, o.ls_done, o.en_after}); end
      checks++; if (o.ls_rdata !== m_ls_rdata) begin failures++;
         $display("FAIL st_rdata_kept got=%0h exp=%0h", o.ls_rdata, m_ls_rdata); end
      @(negedge clk);
   endtask

   task automatic test_priority();
      obs_t o1, o2;
      if_req = 1'b1; if_addr = 32'h200;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_byte_num = 3'd4;
      serve(0, 1'b0, 1'b0, 32'h1111_2222, o1);
      ls_req = 1'b0;
      serve(1, 1'b0, 1'b0, 32'h3333_4444, o2);
      if_req = 1'b0;
      checks++; if (o1.addr !== 32'h40 || o1.ls_done !== 1'b1 || o1.ls_rdata !== 32'h1111_2222) begin failures++;
         $display("FAIL prio_ls_first got=%0h/%b/%0h exp=40/1/11112222", o1.addr, o1.ls_done, o1.ls_rdata); end
      checks++; if (o1.starve !== 8'd1) begin failures++;
         $display("FAIL prio_starve got=%0d exp=1", o1.starve); end
      checks++; if (o1.en_after !== 1'b0 || o2.wait_cycles !== 1 || o2.done_at_grant !== 1'b0) begin failures++;
         $display("FAIL prio_idle_gap got=%b/%0d/%b exp=0/1/0", o1.en_after, o2.wait_cycles, o2.done_at_grant); end
      checks++; if (o2.addr !== 32'h200 || o2.if_done !== 1'b1 || o2.if_rdata !== 32'h3333_4444) begin failures++;
         $display("FAIL prio_if_second got=%0h/%b/%0h exp=200/1/33334444", o2.addr, o2.if_done, o2.if_rdata); end
      checks++; if (o2.starve !== 8'd0) begin failures++;
         $display("FAIL prio_starve_clr got=%0d exp=0", o2.starve); end
      m_ls_rdata = 32'h1111_2222; m_if_rdata = 32'h3333_4444;
      @(negedge clk);
   endtask

   task automatic test_starvation();
      obs_t o;
      if_req = 1'b1; if_addr = 32'h300;
      ls_req = 1'b1; ls_we = 1'b0; ls_byte_num = 3'd2;
      for (int i = 0; i < 5; i++) begin
         ls_addr = 32'h1000 + 32'(i * 4);
         serve(0, 1'b0, 1'b0, 32'hB000_0000 + 32'(i), o);
         checks++; if (o.addr !== ((i == 4) ? 32'h300 : ls_addr)) begin failures++;
            $display("FAIL starve_grant%0d got=%0h exp=%0h", i, o.addr, (i == 4) ? 32'h300 : ls_addr); end
         checks++; if (o.starve !== 8'((i == 4) ? 0 : i + 1)) begin failures++;
            $display("FAIL starve_cnt%0d got=%0d exp=%0d", i, o.starve, (i == 4) ? 0 : i + 1); end
         checks++; if ({o.if_done, o.ls_done} !== ((i == 4) ? 2'b10 : 2'b01) || o.wait_cycles !== 1) begin failures++;
            $display("FAIL starve_done%0d got=%b/%0d", i, {o.if_done, o.ls_done}, o.wait_cycles); end
      end
      if_req = 1'b0; ls_req = 1'b0;
      m_if_rdata = 32'hB000_0004; m_ls_rdata = 32'hB000_0003;
      @(negedge clk);
      checks++; if (dbg_state !== ARB_IDLE || dbg_starve_cnt !== 8'd0 || (mem_rd_en | mem_wr_en)) begin failures++;
         $display("FAIL starve_end got=%0d/%0d/%b exp=0/0/0", dbg_state, dbg_starve_cnt, mem_rd_en | mem_wr_en); end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h60; ls_byte_num = 3'd4; ls_wdata = 32'h1234;
      @(negedge clk);
      checks++; if (mem_wr_en !== 1'b1) begin failures++;
         $display("FAIL rstmid_wr_en got=%b exp=1", mem_wr_en); end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if ({mem_wr_en, mem_rd_en, ls_done} !== 3'b000 || dbg_state !== ARB_IDLE) begin failures++;
         $display("FAIL rstmid_async got=%b/%0d exp=000/0", {mem_wr_en, mem_rd_en, ls_done}, dbg_state); end
      ls_req = 1'b0;
      m_if_rdata = '0; m_ls_rdata = '0; m_starve = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({mem_wr_en, mem_rd_en, ls_done, if_done} !== 4'b0000) begin failures++;
         $display("FAIL rstmid_no_done got=%b exp=0000", {mem_wr_en, mem_rd_en, ls_done, if_done}); end
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
      serve(1, 1'b0, 1'b0, 32'hFEED_0044, o);
      ls_req = 1'b0;
      checks++; if (o.wait_cycles !== 1 || o.addr !== 32'h44 || o.ls_done !== 1'b1 || o.ls_rdata !== 32'hFEED_0044) begin failures++;
         $display("FAIL rstmid_fresh got=%0d/%0h/%b/%0h", o.wait_cycles, o.addr, o.ls_done, o.ls_rdata); end
      m_ls_rdata = 32'hFEED_0044;
      @(negedge clk);
   endtask

   task automatic test_idle_done_and_drop();
      obs_t o;
      mem_rdata = 32'hDEAD_BEEF; mem_rd_done = 1'b1; mem_wr_done = 1'b1;
      @(negedge clk);
      mem_rd_done = 1'b0; mem_wr_done = 1'b0;
      checks++; if ({if_done, ls_done, mem_rd_en, mem_wr_en} !== 4'b0000 ||
                    if_rdata !== m_if_rdata || ls_rdata !== m_ls_rdata || dbg_state !== ARB_IDLE) begin failures++;
         $display("FAIL idle_done got=%b/%0h/%0h exp=0000/%0h/%0h", {if_done, ls_done, mem_rd_en, mem_wr_en},
                  if_rdata, ls_rdata, m_if_rdata, m_ls_rdata); end
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80; ls_byte_num = 3'd4;
      serve(2, 1'b0, 1'b1, 32'h0BAD_F00D, o);
      checks++; if (o.ls_done !== 1'b1 || o.ls_rdata !== 32'h0BAD_F00D) begin failures++;
         $display("FAIL drop_done got=%b/%0h exp=1/badf00d", o.ls_done, o.ls_rdata); end
      m_ls_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      checks++; if ({ls_done, mem_rd_en, mem_wr_en} !== 3'b000) begin failures++;
         $display("FAIL drop_single_pulse got=%b exp=000", {ls_done, mem_rd_en, mem_wr_en}); end
   endtask

   task automatic test_random();
      obs_t o;
      bit if_pend, ls_pend, exp_if, exp_rd;
      logic [DATA_W-1:0] rdata, exp_data;
      do_reset();
      if_pend = 1'b0; ls_pend = 1'b0;
      for (int n = 0; n < 80; n++) begin
         if (!if_pend && $urandom_range(0, 1) == 1) begin if_pend = 1'b1; if_addr = $urandom; end
         if (!ls_pend && ($urandom_range(0, 3) != 0 || !if_pend)) begin
            ls_pend = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom; ls_wdata = $urandom;
            case ($urandom_range(0, 2))
               0:       ls_byte_num = 3'd1;
               1:       ls_byte_num = 3'd2;
               default: ls_byte_num = 3'd4;
            endcase
         end
         if_req = if_pend; ls_req = ls_pend;
         exp_if = model_grant_if(if_pend, ls_pend);
         model_update(exp_if, if_pend);
         exp_rd = exp_if || !ls_we;
         rdata = $urandom;
         if (exp_rd) exp_q.push_back(rdata);
         serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, rdata, o);
         checks++; if (o.wait_cycles !== 1 || o.done_at_grant !== 1'b0 || {o.rd_en, o.wr_en} !== {exp_rd, !exp_rd}) begin failures++;
            $display("FAIL rnd_grant n=%0d got=%0d/%b/%b%b exp=1/0/%b%b", n, o.wait_cycles, o.done_at_grant,
                     o.rd_en, o.wr_en, exp_rd, !exp_rd); end
         checks++; if (o.addr !== (exp_if ? if_addr : ls_addr) || o.byte_num !== (exp_if ? 3'd4 : ls_byte_num)) begin failures++;
            $display("FAIL rnd_payload n=%0d got=%0h/%0d exp=%0h/%0d", n, o.addr, o.byte_num,
                     exp_if ? if_addr : ls_addr, exp_if ? 3'd4 : ls_byte_num); end
         if (!exp_rd) begin
            checks++; if (o.wdata !== ls_wdata) begin failures++;
               $display("FAIL rnd_wdata n=%0d got=%0h exp=%0h", n, o.wdata, ls_wdata); end
         end
         checks++; if (o.starve !== 8'(m_starve)) begin failures++;
            $display("FAIL rnd_starve n=%0d got=%0d exp=%0d", n, o.starve, m_starve); end
         checks++; if (!o.spur_ok || !o.held || o.en_after !== 1'b0 || {o.if_done, o.ls_done} !== {exp_if, !exp_if}) begin failures++;
            $display("FAIL rnd_done n=%0d got=%b%b/%b/%b%b exp=11/0/%b%b", n, o.spur_ok, o.held, o.en_after,
                     o.if_done, o.ls_done, exp_if, !exp_if); end
         if (exp_rd && exp_q.size() > 0) begin
            exp_data = exp_q.pop_front();
            if (exp_if) m_if_rdata = exp_data; else m_ls_rdata = exp_data;
         end
         checks++; if (o.if_rdata !== m_if_rdata || o.ls_rdata !== m_ls_rdata) begin failures++;
            $display("FAIL rnd_rdata n=%0d got=%0h/%0h exp=%0h/%0h", n, o.if_rdata, o.ls_rdata, m_if_rdata, m_ls_rdata); end
         if (exp_if) if_pend = 1'b0; else ls_pend = 1'b0;
         if_req = if_pend; ls_req = ls_pend;
      end
      if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_if_read();
      test_ls_store();
      test_priority();
      test_starvation();
      test_reset_mid();
      test_idle_done_and_drop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
